// File: rtl/sprite_row_fetcher_if.sv
// Bundles the row-request, sprite-storage read and pixel-stream signals of the
// sprite row fetcher. slave is the fetcher's view; master is the surrounding system.
interface sprite_row_fetcher_if #(
    parameter int SPRITE_NUM    = 16,
    parameter int SPRITE_WIDTH  = 32,
    parameter int SPRITE_HEIGHT = 32,
    parameter int ADDR_W        = $clog2(SPRITE_WIDTH * SPRITE_HEIGHT)
);
    localparam int SEL_W = $clog2(SPRITE_NUM);

    // row request
    logic             req_valid;
    logic             req_ready;
    logic [SEL_W-1:0] req_select;
    logic [7:0]       req_row;
    logic             req_flip;
    logic             req_err;

    // sprite storage read port
    logic [SEL_W-1:0]  r_select;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_data;

    // pixel stream
    logic       pix_valid;
    logic       pix_ready;
    logic [3:0] pix_data;
    logic       pix_opaque;
    logic       pix_last;

    modport slave (
        input  req_valid, req_select, req_row, req_flip, r_data, pix_ready,
        output req_ready, req_err, r_select, r_addr, pix_valid, pix_data, pix_opaque, pix_last
    );

    modport master (
        output req_valid, req_select, req_row, req_flip, r_data, pix_ready,
        input  req_ready, req_err, r_select, r_addr, pix_valid, pix_data, pix_opaque, pix_last
    );
endinterface

// File: rtl/sprite_row_fetcher.sv
// Fetches one row of a stored sprite through a 1-cycle-latency read port and
// streams it as backpressured 4-bit pixels, optionally mirrored horizontally.
module sprite_row_fetcher #(
    parameter int SPRITE_NUM    = 16,
    parameter int SPRITE_WIDTH  = 32,
    parameter int SPRITE_HEIGHT = 32,
    parameter int ADDR_W        = $clog2(SPRITE_WIDTH * SPRITE_HEIGHT)
) (
    input logic                  clock,
    input logic                  reset,
    sprite_row_fetcher_if.slave  bus
);
    localparam int SEL_W = $clog2(SPRITE_NUM);
    localparam int COL_W = $clog2(SPRITE_WIDTH);
    localparam int ROW_W = ADDR_W - COL_W;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    typedef struct packed {
        logic       last;
        logic [3:0] data;
    } entry_t;

    state_t state, state_next;

    logic [SEL_W-1:0]  sel_q;
    logic [ROW_W-1:0]  row_q;
    logic              flip_q;
    logic [COL_W-1:0]  col_q;
    logic              inflight_q;
    logic              inflight_last_q;
    logic [ADDR_W-1:0] addr_q;
    logic [SEL_W-1:0]  r_select_q;
    logic              req_err_q;

    entry_t     fifo_mem [2];
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] fifo_count;
    entry_t     head;

    logic              req_bad;
    logic              accept;
    logic              reject;
    logic              issue;
    logic              push;
    logic              pop;
    logic              fifo_valid;
    logic              col_is_last;
    logic              credit;
    logic [2:0]        occupancy;
    logic [COL_W-1:0]  col_eff;
    logic [ADDR_W-1:0] fetch_addr;

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    assign req_bad = (32'(bus.req_select) >= SPRITE_NUM) || (32'(bus.req_row) >= SPRITE_HEIGHT);

    assign fifo_valid  = (fifo_count != 2'd0);
    assign pop         = fifo_valid && bus.pix_ready;
    assign push        = inflight_q;
    assign col_is_last = &col_q;

    // Credit counts the slot freed by this cycle's pop so that an unstalled
    // consumer sees one pixel per clock without the FIFO ever exceeding 2.
    assign occupancy = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
    assign credit    = (occupancy < 3'd2);

    // Widths are powers of two, so row*W + col is a concatenation and the
    // mirrored column W-1-col is the bitwise complement.
    assign col_eff    = flip_q ? ~col_q : col_q;
    assign fetch_addr = {row_q, col_eff};

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next    = state;
        issue         = 1'b0;
        accept        = 1'b0;
        reject        = 1'b0;
        bus.req_ready = 1'b0;
        unique case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (req_bad) begin
                        reject = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        state_next = FETCH;
                    end
                end
            end
            FETCH: begin
                if (credit) begin
                    issue = 1'b1;
                    if (col_is_last) state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && head.last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch, column counter and read-port registers
    // ------------------------------------------------------------------
    // NOTE: sequential state is updated with <= only, so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clock) begin
        if (reset) begin
            sel_q           <= '0;
            row_q           <= '0;
            flip_q          <= 1'b0;
            col_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            addr_q          <= '0;
            r_select_q      <= '0;
            req_err_q       <= 1'b0;
        end else begin
            req_err_q       <= reject;
            inflight_q      <= issue;
            inflight_last_q <= issue && col_is_last;
            if (accept) begin
                sel_q  <= bus.req_select;
                row_q  <= bus.req_row[ROW_W-1:0];
                flip_q <= bus.req_flip;
                col_q  <= '0;
            end
            if (issue) begin
                col_q      <= col_q + COL_W'(1);
                addr_q     <= fetch_addr;
                r_select_q <= sel_q;
            end
        end
    end

    // The read port shows the new address in the issue cycle and holds it otherwise.
    assign bus.r_addr   = issue ? fetch_addr : addr_q;
    assign bus.r_select = issue ? sel_q      : r_select_q;
    assign bus.req_err  = req_err_q;

    // ------------------------------------------------------------------
    // Two-entry pixel FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            fifo_count <= fifo_count + 2'(push) - 2'(pop);
        end
    end

    // NOTE: storage entries carry no reset; they are only observed behind
    // fifo_valid, which the pointer/count reset already guarantees is 0.
    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= '{last: inflight_last_q, data: bus.r_data};
    end

    assign head = fifo_mem[rd_ptr];

    assign bus.pix_valid  = fifo_valid;
    assign bus.pix_data   = fifo_valid ? head.data : 4'd0;
    assign bus.pix_last   = fifo_valid && head.last;
    assign bus.pix_opaque = (bus.pix_data != 4'd0);

    // ------------------------------------------------------------------
    // Design-error checks
    // ------------------------------------------------------------------
    fifo_no_overflow: assert property (
        @(posedge clock) disable iff (reset) !(push && !pop && fifo_count == 2'd2)
    );

    err_only_when_idle: assert property (
        @(posedge clock) disable iff (reset) !(reject && state_next != IDLE)
    );

endmodule

// File: tb/tb_sprite_row_fetcher.sv
// Directed self-checking bench for sprite_row_fetcher: a BRAM model answers reads,
// a scoreboard of expected addresses and pixels is filled per request and drained.
module tb_sprite_row_fetcher;
    localparam int SPRITE_NUM    = 16;
    localparam int SPRITE_WIDTH  = 32;
    localparam int SPRITE_HEIGHT = 32;

    typedef struct packed {
        logic [3:0] d;
        logic       last;
    } px_t;

    logic clock;
    logic reset;

    sprite_row_fetcher_if #(
        .SPRITE_NUM(SPRITE_NUM), .SPRITE_WIDTH(SPRITE_WIDTH), .SPRITE_HEIGHT(SPRITE_HEIGHT)
    ) bus ();

    sprite_row_fetcher #(
        .SPRITE_NUM(SPRITE_NUM), .SPRITE_WIDTH(SPRITE_WIDTH), .SPRITE_HEIGHT(SPRITE_HEIGHT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Sprite storage model with one cycle of read latency.
    logic [3:0] store [SPRITE_NUM][SPRITE_WIDTH*SPRITE_HEIGHT];
    always @(posedge clock) bus.r_data <= store[bus.r_select][bus.r_addr];

    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    int  t_acc    = 0;
    int  issued   = 0;
    int  popped   = 0;
    int  row_pix  = 0;
    int  ready_mode = 0;
    int  cur_select = 0;
    bit  mon_en   = 1'b1;
    bit  strict   = 1'b0;
    bit  row_active = 1'b0;
    bit  first_issue_pending = 1'b0;
    logic [31:0] prev_addr = '0;

    int  exp_addr [$];
    px_t exp_pix  [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic monitor();
        bit  issue_now = 1'b0;
        px_t e;
        if (first_issue_pending) begin
            issue_now           = 1'b1;
            first_issue_pending = 1'b0;
        end else if (row_active && 32'(bus.r_addr) !== prev_addr) begin
            issue_now = 1'b1;
        end
        prev_addr = 32'(bus.r_addr);
        if (issue_now) begin
            issued++;
            if (exp_addr.size() == 0) chk("spurious_read", 32'(bus.r_addr), 32'hFFFF_FFFF);
            else                      chk("r_addr", 32'(bus.r_addr), exp_addr.pop_front());
            chk("r_select", 32'(bus.r_select), cur_select);
        end
        if (bus.pix_valid && bus.pix_ready) begin
            popped++;
            if (exp_pix.size() == 0) begin
                chk("spurious_pixel", 32'(bus.pix_data), 32'hFFFF_FFFF);
            end else begin
                e = exp_pix.pop_front();
                row_pix++;
                chk("pix_data",   32'(bus.pix_data), 32'(e.d));
                chk("pix_last",   32'(bus.pix_last), 32'(e.last));
                chk("pix_opaque", 32'(bus.pix_opaque), 32'(e.d != 4'd0));
                if (strict && row_pix == 1) chk("first_pix_cycle", cyc, t_acc + 3);
                if (e.last) begin
                    row_active = 1'b0;
                    chk("row_pixel_count", row_pix, SPRITE_WIDTH);
                    if (strict) chk("last_pix_cycle", cyc, t_acc + 2 + SPRITE_WIDTH);
                end
            end
        end
        if (issue_now) chk("outstanding_le_2", 32'((issued - popped) <= 2), 1);
    endtask

    // One clock: drive pix_ready, observe mid-cycle, advance to the next falling edge.
    task automatic step();
        bus.pix_ready = (ready_mode == 0) ? 1'b1 : (cyc % 3 == 0);
        #1;
        if (mon_en) monitor();
        @(negedge clock);
        cyc++;
    endtask

    task automatic request(input int sel, input int row, input bit flip);
        int a;
        bus.req_valid  = 1'b1;
        bus.req_select = 4'(sel);
        bus.req_row    = 8'(row);
        bus.req_flip   = flip;
        #1 chk("req_ready_on_request", 32'(bus.req_ready), 1);
        for (int c = 0; c < SPRITE_WIDTH; c++) begin
            a = row * SPRITE_WIDTH + (flip ? SPRITE_WIDTH - 1 - c : c);
            exp_addr.push_back(a);
            exp_pix.push_back('{d: store[sel][a], last: (c == SPRITE_WIDTH - 1)});
        end
        t_acc  = cyc;
        strict = (ready_mode == 0);
        step();
        bus.req_valid       = 1'b0;
        cur_select          = sel;
        row_active          = 1'b1;
        first_issue_pending = 1'b1;
        row_pix             = 0;
    endtask

    task automatic wait_row();
        for (int i = 0; i < 400 && row_active; i++) step();
        if (row_active) begin
            chk("row_timeout", 0, 1);
            row_active = 1'b0;
        end
    endtask

    task automatic reject_request(input int sel, input int row);
        logic [31:0] held_addr;
        bus.req_valid  = 1'b1;
        bus.req_select = 4'(sel);
        bus.req_row    = 8'(row);
        bus.req_flip   = 1'b0;
        #1 chk("err_req_ready", 32'(bus.req_ready), 1);
        chk("err_not_early", 32'(bus.req_err), 0);
        held_addr = 32'(bus.r_addr);
        step();
        bus.req_valid = 1'b0;
        #1 chk("err_pulse", 32'(bus.req_err), 1);
        chk("err_r_addr_held", 32'(bus.r_addr), held_addr);
        step();
        #1 chk("err_single_pulse", 32'(bus.req_err), 0);
        chk("err_stays_idle", 32'(bus.req_ready), 1);
        chk("err_no_pixels", 32'(bus.pix_valid), 0);
        chk("err_r_addr_still", 32'(bus.r_addr), held_addr);
        step();
    endtask

    initial begin
        int start_pop;
        bus.req_valid  = 1'b0;
        bus.req_select = '0;
        bus.req_row    = '0;
        bus.req_flip   = 1'b0;
        bus.pix_ready  = 1'b1;
        for (int s = 0; s < SPRITE_NUM; s++)
            for (int a = 0; a < SPRITE_WIDTH * SPRITE_HEIGHT; a++)
                store[s][a] = 4'($urandom_range(0, 15));
        for (int c = 0; c < SPRITE_WIDTH; c++) store[3][5 * SPRITE_WIDTH + c] = 4'(c);

        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_req_ready",  32'(bus.req_ready), 1);
        chk("rst_req_err",    32'(bus.req_err), 0);
        chk("rst_pix_valid",  32'(bus.pix_valid), 0);
        chk("rst_pix_last",   32'(bus.pix_last), 0);
        chk("rst_pix_data",   32'(bus.pix_data), 0);
        chk("rst_pix_opaque", 32'(bus.pix_opaque), 0);
        chk("rst_r_addr",     32'(bus.r_addr), 0);
        chk("rst_r_select",   32'(bus.r_select), 0);

        // Sprite 3 row 5, straight order, consumer always ready.
        ready_mode = 0;
        request(3, 5, 1'b0);
        wait_row();
        #1 chk("ready_after_row", 32'(bus.req_ready), 1);

        // Backpressure: consumer ready one cycle in three.
        ready_mode = 1;
        request(3, 7, 1'b0);
        wait_row();
        ready_mode = 0;

        // Same row mirrored.
        request(3, 5, 1'b1);
        wait_row();

        // Out-of-range rows are rejected without touching the read port.
        reject_request(3, 32);
        reject_request(0, 200);

        // Reset in the middle of a fetch.
        request(3, 2, 1'b0);
        for (int i = 0; i < 100 && row_pix < 10; i++) step();
        chk("mid_fetch_busy", 32'(bus.req_ready), 0);
        mon_en = 1'b0;
        reset  = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("post_rst_pix_valid", 32'(bus.pix_valid), 0);
        chk("post_rst_req_ready", 32'(bus.req_ready), 1);
        chk("post_rst_r_addr",    32'(bus.r_addr), 0);
        exp_addr.delete();
        exp_pix.delete();
        row_active          = 1'b0;
        first_issue_pending = 1'b0;
        issued              = 0;
        popped              = 0;
        mon_en              = 1'b1;
        repeat (3) step();
        #1 chk("no_stale_pixel", 32'(bus.pix_valid), 0);
        request(5, 0, 1'b0);
        wait_row();

        // Back-to-back rows 0 and 31.
        start_pop = popped;
        request(3, 0, 1'b0);
        wait_row();
        request(3, 31, 1'b0);
        wait_row();
        chk("b2b_pixel_total", popped - start_pop, 2 * SPRITE_WIDTH);

        repeat (3) step();
        chk("scoreboard_pix_empty",  exp_pix.size(), 0);
        chk("scoreboard_addr_empty", exp_addr.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
